acq_sequencer: RTL and testbench

Run controller for the ADC event-acquisition datapath.
- Qualifies the threshold-crossing trigger and gates writes into the 64-bit sample FIFO.
- Enforces a programmable dead time after each accepted event and stops after a programmed number of events.
- Counts accepted and lost (FIFO-full) events for readback over the system-bus register bank.

---
 rtl/acq_sequencer.sv | 131 +++++++++++++
 tb/tb_acq_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/acq_sequencer.sv
// Run controller for the ADC event-acquisition path: qualifies trigger edges,
// gates sample-FIFO writes, applies dead time and an event limit, counts events.
module acq_sequencer #(
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned HOLD_W = 16
) (
   input  logic              clk,
   input  logic              rstn_i,
   input  logic              cfg_arm_i,
   input  logic              cfg_abort_i,
   input  logic [HOLD_W-1:0] cfg_holdoff_i,
   input  logic [CNT_W-1:0]  cfg_event_limit_i,
   input  logic              trig_i,
   input  logic              fifo_full_i,
   output logic              wr_en_o,
   output logic [1:0]        state_o,
   output logic [CNT_W-1:0]  event_cnt_o,
   output logic [CNT_W-1:0]  lost_cnt_o,
   output logic              overflow_o,
   output logic              done_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                trig_q;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [CNT_W-1:0]    evt_q, evt_d;
   logic [CNT_W-1:0]    lost_q, lost_d;
   logic                ovf_q, ovf_d;
   logic                wr_q, wr_d;
   logic                done_q, done_d;

   logic                trig_edge;
   logic [CNT_W:0]      evt_plus1;
   logic [CNT_W-1:0]    evt_sat;
   logic [CNT_W-1:0]    lost_sat;
   logic                limit_hit;

   assign trig_edge = trig_i & ~trig_q;

   // Limit compare is done one bit wider so a saturated count never aliases to 0.
   assign evt_plus1 = {1'b0, evt_q} + (CNT_W+1)'(1);
   assign evt_sat   = (&evt_q)  ? evt_q  : evt_plus1[CNT_W-1:0];
   assign lost_sat  = (&lost_q) ? lost_q : lost_q + CNT_W'(1);
   assign limit_hit = (cfg_event_limit_i != '0) &&
                      (evt_plus1 == {1'b0, cfg_event_limit_i});

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      evt_d   = evt_q;
      lost_d  = lost_q;
      ovf_d   = ovf_q;
      wr_d    = 1'b0;
      done_d  = 1'b0;

      if (cfg_abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cfg_arm_i) begin
                  state_d = ST_ARMED;
                  evt_d   = '0;
                  lost_d  = '0;
                  ovf_d   = 1'b0;
               end
            end
            ST_ARMED: begin
               if (trig_edge && !fifo_full_i) begin
                  wr_d  = 1'b1;
                  evt_d = evt_sat;
                  if (limit_hit) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else if (cfg_holdoff_i != '0) begin
                     state_d = ST_HOLDOFF;
                     hold_d  = cfg_holdoff_i - HOLD_W'(1);
                  end
               end else if (trig_edge && fifo_full_i) begin
                  lost_d = lost_sat;
                  ovf_d  = 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (hold_q == '0) begin
                  state_d = ST_ARMED;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         trig_q  <= 1'b0;
         hold_q  <= '0;
         evt_q   <= '0;
         lost_q  <= '0;
         ovf_q   <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         trig_q  <= trig_i;
         hold_q  <= hold_d;
         evt_q   <= evt_d;
         lost_q  <= lost_d;
         ovf_q   <= ovf_d;
         wr_q    <= wr_d;
         done_q  <= done_d;
      end
   end

   assign wr_en_o     = wr_q;
   assign state_o     = state_q;
   assign event_cnt_o = evt_q;
   assign lost_cnt_o  = lost_q;
   assign overflow_o  = ovf_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed self-checking bench for acq_sequencer: limit, holdoff, FIFO-full,
// held trigger, abort priority and asynchronous reset.
module tb_acq_sequencer;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        cfg_arm_i;
   logic        cfg_abort_i;
   logic [15:0] cfg_holdoff_i;
   logic [31:0] cfg_event_limit_i;
   logic        trig_i;
   logic        fifo_full_i;
   logic        wr_en_o;
   logic [1:0]  state_o;
   logic [31:0] event_cnt_o;
   logic [31:0] lost_cnt_o;
   logic        overflow_o;
   logic        done_o;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_seen;

   always #5 clk = ~clk;

   acq_sequencer #(
      .CNT_W  (32),
      .HOLD_W (16)
   ) dut (
      .clk               (clk),
      .rstn_i            (rstn_i),
      .cfg_arm_i         (cfg_arm_i),
      .cfg_abort_i       (cfg_abort_i),
      .cfg_holdoff_i     (cfg_holdoff_i),
      .cfg_event_limit_i (cfg_event_limit_i),
      .trig_i            (trig_i),
      .fifo_full_i       (fifo_full_i),
      .wr_en_o           (wr_en_o),
      .state_o           (state_o),
      .event_cnt_o       (event_cnt_o),
      .lost_cnt_o        (lost_cnt_o),
      .overflow_o        (overflow_o),
      .done_o            (done_o)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs driven here hold for one cycle; outputs read afterwards are the
   // registered result of that cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_state"}, 32'(state_o), 32'd0);
      check_val({tag, "_wr"},    32'(wr_en_o), 32'd0);
      check_val({tag, "_evt"},   event_cnt_o, 32'd0);
      check_val({tag, "_lost"},  lost_cnt_o, 32'd0);
      check_val({tag, "_ovf"},   32'(overflow_o), 32'd0);
      check_val({tag, "_done"},  32'(done_o), 32'd0);
   endtask

   initial begin
      rstn_i = 1'b0; cfg_arm_i = 1'b0; cfg_abort_i = 1'b0;
      cfg_holdoff_i = '0; cfg_event_limit_i = '0;
      trig_i = 1'b0; fifo_full_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rstn_i = 1'b1;

      // Limit 3, no holdoff: edges 10 cycles apart, third one ends the run.
      cfg_event_limit_i = 32'd3;
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      check_val("t1_armed", 32'(state_o), 32'd1);
      for (int e = 1; e <= 3; e++) begin
         wr_seen = 0;
         repeat (9) begin tick(); wr_seen += int'(wr_en_o); end
         check_val("t1_idle_wr", 32'(wr_seen), 32'd0);
         trig_i = 1'b1; tick(); trig_i = 1'b0;
         check_val("t1_wr",    32'(wr_en_o), 32'd1);
         check_val("t1_evt",   event_cnt_o, 32'(e));
         check_val("t1_done",  32'(done_o), (e == 3) ? 32'd1 : 32'd0);
         check_val("t1_state", 32'(state_o), (e == 3) ? 32'd0 : 32'd1);
      end
      tick();
      check_val("t1_done_clr", 32'(done_o), 32'd0);
      check_val("t1_wr_clr",   32'(wr_en_o), 32'd0);

      // Holdoff 5, unlimited: edges at rel 0, 3, 6; rel 3 falls in HOLDOFF.
      cfg_event_limit_i = '0; cfg_holdoff_i = 16'd5;
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      tick();
      for (int c = 0; c < 8; c++) begin
         trig_i = (c == 0 || c == 3 || c == 6);
         tick();
         check_val("t2_state", 32'(state_o), (c == 5) ? 32'd1 : 32'd2);
         check_val("t2_wr",    32'(wr_en_o), (c == 0 || c == 6) ? 32'd1 : 32'd0);
      end
      trig_i = 1'b0;
      check_val("t2_evt",  event_cnt_o, 32'd2);
      check_val("t2_lost", lost_cnt_o, 32'd0);

      // FIFO full drops the event; arm while running is ignored; abort keeps counts.
      cfg_abort_i = 1'b1; tick(); cfg_abort_i = 1'b0;
      check_val("t3_abort_idle", 32'(state_o), 32'd0);
      cfg_holdoff_i = '0;
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      repeat (3) tick();
      trig_i = 1'b1; fifo_full_i = 1'b1; tick(); trig_i = 1'b0; fifo_full_i = 1'b0;
      check_val("t3_full_wr",   32'(wr_en_o), 32'd0);
      check_val("t3_full_lost", lost_cnt_o, 32'd1);
      check_val("t3_full_ovf",  32'(overflow_o), 32'd1);
      check_val("t3_full_st",   32'(state_o), 32'd1);
      check_val("t3_full_evt",  event_cnt_o, 32'd0);
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      check_val("t3_rearm_ign", lost_cnt_o, 32'd1);
      repeat (7) tick();
      trig_i = 1'b1; tick(); trig_i = 1'b0;
      check_val("t3_acc_wr",  32'(wr_en_o), 32'd1);
      check_val("t3_acc_evt", event_cnt_o, 32'd1);
      cfg_abort_i = 1'b1; tick(); cfg_abort_i = 1'b0;
      check_val("t3_hold_lost", lost_cnt_o, 32'd1);
      check_val("t3_hold_ovf",  32'(overflow_o), 32'd1);
      check_val("t3_hold_evt",  event_cnt_o, 32'd1);
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      check_val("t3_clr_evt",  event_cnt_o, 32'd0);
      check_val("t3_clr_lost", lost_cnt_o, 32'd0);
      check_val("t3_clr_ovf",  32'(overflow_o), 32'd0);

      // Trigger held high for 50 cycles yields a single write.
      trig_i = 1'b1;
      wr_seen = 0;
      repeat (50) begin tick(); wr_seen += int'(wr_en_o); end
      trig_i = 1'b0; tick(); wr_seen += int'(wr_en_o);
      check_val("t4_wr_pulses", 32'(wr_seen), 32'd1);
      check_val("t4_evt",       event_cnt_o, 32'd1);

      // Limit lowered below the running count never matches.
      trig_i = 1'b1; tick(); trig_i = 1'b0; tick();
      cfg_event_limit_i = 32'd1;
      trig_i = 1'b1; tick(); trig_i = 1'b0;
      check_val("t4b_evt",   event_cnt_o, 32'd3);
      check_val("t4b_done",  32'(done_o), 32'd0);
      check_val("t4b_state", 32'(state_o), 32'd1);
      tick();
      cfg_event_limit_i = '0;

      // Abort coinciding with an accepting edge wins.
      trig_i = 1'b1; cfg_abort_i = 1'b1; tick(); trig_i = 1'b0; cfg_abort_i = 1'b0;
      check_val("t5_wr",    32'(wr_en_o), 32'd0);
      check_val("t5_evt",   event_cnt_o, 32'd3);
      check_val("t5_state", 32'(state_o), 32'd0);
      check_val("t5_done",  32'(done_o), 32'd0);
      tick();
      check_val("t5_wr2",   32'(wr_en_o), 32'd0);
      check_val("t5_done2", 32'(done_o), 32'd0);

      // Asynchronous reset between clock edges while in HOLDOFF.
      cfg_holdoff_i = 16'd20;
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      trig_i = 1'b1; tick(); trig_i = 1'b0;
      check_val("t6_wr",      32'(wr_en_o), 32'd1);
      check_val("t6_holdoff", 32'(state_o), 32'd2);
      repeat (3) tick();
      #2 rstn_i = 1'b0;
      #1;
      check_all_zero("t6_async");
      @(negedge clk);
      rstn_i = 1'b1;
      cfg_holdoff_i = '0;
      cfg_arm_i = 1'b1; tick(); cfg_arm_i = 1'b0;
      check_val("t6_rearm", 32'(state_o), 32'd1);
      trig_i = 1'b1; tick(); trig_i = 1'b0;
      check_val("t6_acc_wr",  32'(wr_en_o), 32'd1);
      check_val("t6_acc_evt", event_cnt_o, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
